// File: rtl/instr_prefetch_buffer_if.sv
// Bundles the instruction-memory handshake, the fetch-side valid/ready port and the
// execute-stage redirect for the prefetch buffer.
interface instr_prefetch_buffer_if;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic [31:0] o_pc_inc;
    logic        i_ready;
    logic        o_proto_err;

    modport master (
        input  i_redirect, i_redirect_pc, i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_ready,
        output o_imem_req, o_imem_addr, o_valid, o_inst, o_pc, o_pc_inc, o_proto_err
    );

    modport slave (
        output i_redirect, i_redirect_pc, i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_ready,
        input  o_imem_req, o_imem_addr, o_valid, o_inst, o_pc, o_pc_inc, o_proto_err
    );
endinterface

// File: rtl/instr_prefetch_buffer.sv
// In-order instruction prefetch buffer: credit-limited word fetches, a DEPTH-entry FIFO of
// {inst, pc}, and redirect flushing that drops responses still in flight.
module instr_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                     clk,
    input logic                     reset,
    instr_prefetch_buffer_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    cnt_t          count_q, count_d, outst_q, outst_d, drop_q, drop_d;
    logic [31:0]   req_pc_q, req_pc_d, resp_pc_q, resp_pc_d;
    logic          proto_err_q, proto_err_d;

    logic [CW:0]   credit_used;
    logic [CW:0]   drop_sum;
    cnt_t          outst_after_rsp;
    logic          req, accept, rsp_ok, spurious, push, pop;

    // Buffered plus outstanding fetches never exceed DEPTH, so a push always finds room.
    assign credit_used     = {1'b0, count_q} + {1'b0, outst_q};
    assign req             = !reset && !bus.i_redirect && (credit_used < (CW+1)'(DEPTH));
    assign accept          = req && bus.i_imem_gnt;
    assign rsp_ok          = bus.i_imem_rvalid && (outst_q != '0);
    assign spurious        = bus.i_imem_rvalid && (outst_q == '0);
    assign push            = rsp_ok && (drop_q == '0);
    assign pop             = (count_q != '0) && bus.i_ready;
    assign outst_after_rsp = outst_q - cnt_t'(rsp_ok);
    assign drop_sum        = {1'b0, drop_q} + {1'b0, outst_after_rsp};

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        req_pc_d    = req_pc_q;
        resp_pc_d   = resp_pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        drop_d      = drop_q;
        outst_d     = outst_q + cnt_t'(accept) - cnt_t'(rsp_ok);
        proto_err_d = proto_err_q | spurious;

        if (bus.i_redirect) begin
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            req_pc_d  = bus.i_redirect_pc;
            resp_pc_d = bus.i_redirect_pc;
            // Everything still in flight is stale; the drop count cannot exceed it.
            drop_d    = (drop_sum > {1'b0, outst_after_rsp}) ? outst_after_rsp
                                                              : drop_sum[CW-1:0];
        end else begin
            if (accept) begin
                req_pc_d = req_pc_q + 32'd4;
            end
            if (rsp_ok) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - cnt_t'(1);
                end else begin
                    resp_pc_d = resp_pc_q + 32'd4;
                    wr_ptr_d  = wr_ptr_q + PW'(1);
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_pc_q    <= RESET_PC;
            resp_pc_q   <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            outst_q     <= '0;
            drop_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            req_pc_q    <= req_pc_d;
            resp_pc_q   <= resp_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            proto_err_q <= proto_err_d;
        end
    end

    // NOTE: the storage array has no reset; count_q gates every read, so its contents
    // never matter until written.
    always_ff @(posedge clk) begin
        if (!bus.i_redirect && push) begin
            fifo_q[wr_ptr_q] <= '{inst: bus.i_imem_rdata, pc: resp_pc_q};
        end
    end

    assign head = fifo_q[rd_ptr_q];

    assign bus.o_imem_req  = req;
    assign bus.o_imem_addr = req_pc_q;
    assign bus.o_valid     = (count_q != '0);
    assign bus.o_inst      = bus.o_valid ? head.inst : '0;
    assign bus.o_pc        = bus.o_valid ? head.pc : '0;
    assign bus.o_pc_inc    = bus.o_valid ? head.pc + 32'd4 : '0;
    assign bus.o_proto_err = proto_err_q;
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer: a latency-configurable memory model, a stimulus
// process that queues expected {pc} per pop, and a monitor that checks each consumed head.
module tb_instr_prefetch_buffer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   c0 = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] exp_q [$];
    logic [31:0] pend_addr [$];
    int          pend_due [$];
    int          mem_lat = 1;
    logic        gnt_en = 1'b1;
    logic        force_rv = 1'b0;
    int          grant_cnt = 0;

    instr_prefetch_buffer_if bus ();

    instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], ~addr[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc - c0);
        end
    endtask

    // Memory model: in-order responses mem_lat cycles after each grant.
    initial begin
        bus.i_imem_gnt    = 1'b0;
        bus.i_imem_rvalid = 1'b0;
        bus.i_imem_rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            bus.i_imem_rvalid = 1'b0;
            bus.i_imem_rdata  = '0;
            bus.i_imem_gnt    = gnt_en;
            if (reset) begin
                pend_addr.delete();
                pend_due.delete();
                grant_cnt = 0;
            end else begin
                if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                    bus.i_imem_rvalid = 1'b1;
                    bus.i_imem_rdata  = mem_word(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end else if (force_rv) begin
                    bus.i_imem_rvalid = 1'b1;
                    bus.i_imem_rdata  = 32'hBAD0_BAD0;
                end
                if (bus.o_imem_req && gnt_en) begin
                    pend_addr.push_back(bus.o_imem_addr);
                    pend_due.push_back(cyc + mem_lat);
                    grant_cnt++;
                end
            end
        end
    end

    // Monitor: every consumed head is compared against the next expected pc.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && !bus.i_redirect && bus.o_valid && bus.i_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pop: got pc %h expected no pop", bus.o_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", bus.o_pc, e);
                    check("pop_inst", bus.o_inst, mem_word(e));
                    check("pop_pc_inc", bus.o_pc_inc, e + 32'd4);
                end
            end
        end
    end

    task automatic to_cycle(input int k);
        while (cyc - c0 < k) @(negedge clk);
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic do_reset(input logic rdy, input int lat);
        @(negedge clk);
        reset             = 1'b1;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = '0;
        bus.i_ready       = rdy;
        mem_lat           = lat;
        gnt_en            = 1'b1;
        force_rv          = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        #3;
        check("rst_imem_req", 32'(bus.o_imem_req), 32'd0);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_inst", bus.o_inst, 32'd0);
        check("rst_pc", bus.o_pc, 32'd0);
        check("rst_pc_inc", bus.o_pc_inc, 32'd0);
        check("rst_proto_err", 32'(bus.o_proto_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        c0    = cyc;
    endtask

    // Waits for the expected queue to empty, then stops consuming.
    task automatic drain(input string name, input int exp_at);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                bus.i_ready = 1'b0;
                if (exp_at >= 0) check(name, 32'(cyc - c0), 32'(exp_at));
                return;
            end
        end
        bus.i_ready = 1'b0;
        n_cmp++;
        n_err++;
        $display("FAIL %s_timeout: got %0d entries left expected 0", name, exp_q.size());
    endtask

    initial begin
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = '0;
        bus.i_ready       = 1'b0;

        // Streaming from reset: first valid two cycles after the first request, then 1/cycle.
        do_reset(1'b1, 1);
        push_seq(32'h0, 8);
        #3;
        check("s_req0", 32'(bus.o_imem_req), 32'd1);
        check("s_addr0", bus.o_imem_addr, 32'h0);
        to_cycle(1);
        #3;
        check("s_addr1", bus.o_imem_addr, 32'h4);
        check("s_valid_c1", 32'(bus.o_valid), 32'd0);
        to_cycle(2);
        #3;
        check("s_valid_c2", 32'(bus.o_valid), 32'd1);
        check("s_pc_c2", bus.o_pc, 32'h0);
        check("s_pc_inc_c2", bus.o_pc_inc, 32'h4);
        drain("s_drain_cycle", 10);

        // Backpressure: credits cap grants at DEPTH, then drain in order and resume at 0x10.
        do_reset(1'b0, 1);
        to_cycle(10);
        #3;
        check("bp_grants", 32'(grant_cnt), 32'd4);
        check("bp_req_low", 32'(bus.o_imem_req), 32'd0);
        check("bp_valid", 32'(bus.o_valid), 32'd1);
        check("bp_head_pc", bus.o_pc, 32'h0);
        to_cycle(11);
        push_seq(32'h0, 8);
        bus.i_ready = 1'b1;
        #3;
        check("bp_req_still_low", 32'(bus.o_imem_req), 32'd0);
        to_cycle(12);
        #3;
        check("bp_resume_req", 32'(bus.o_imem_req), 32'd1);
        check("bp_resume_addr", bus.o_imem_addr, 32'h10);
        drain("bp_drain", -1);

        // Redirect with two fetches outstanding (latency 3): both stale responses dropped.
        do_reset(1'b1, 3);
        push_seq(32'h100, 8);
        to_cycle(2);
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h100;
        #3;
        check("rd_req_low", 32'(bus.o_imem_req), 32'd0);
        to_cycle(3);
        bus.i_redirect = 1'b0;
        #3;
        check("rd_new_addr", bus.o_imem_addr, 32'h100);
        for (int k = 3; k <= 6; k++) begin
            to_cycle(k);
            #3;
            check("rd_valid_gap", 32'(bus.o_valid), 32'd0);
        end
        to_cycle(7);
        #3;
        check("rd_first_valid", 32'(bus.o_valid), 32'd1);
        check("rd_first_pc", bus.o_pc, 32'h100);
        drain("rd_drain", -1);

        // Redirect in a cycle with rvalid and a pop (latency 2): neither takes effect.
        do_reset(1'b1, 2);
        push_seq(32'h0, 3);
        push_seq(32'h200, 8);
        to_cycle(6);
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h200;
        #3;
        check("rp_head_before", bus.o_pc, 32'hC);
        to_cycle(7);
        bus.i_redirect = 1'b0;
        for (int k = 7; k <= 9; k++) begin
            to_cycle(k);
            #3;
            check("rp_valid_gap", 32'(bus.o_valid), 32'd0);
        end
        to_cycle(10);
        #3;
        check("rp_first_pc", bus.o_pc, 32'h200);
        drain("rp_drain", -1);

        // Grant withheld for 5 cycles: request and address hold steady.
        do_reset(1'b0, 1);
        to_cycle(2);
        gnt_en = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            to_cycle(k);
            #3;
            check("gw_req", 32'(bus.o_imem_req), 32'd1);
            check("gw_addr", bus.o_imem_addr, 32'h8);
        end
        check("gw_grants", 32'(grant_cnt), 32'd2);
        to_cycle(7);
        gnt_en = 1'b1;
        to_cycle(8);
        #3;
        check("gw_next_addr", bus.o_imem_addr, 32'hC);

        // Spurious rvalid with nothing outstanding: sticky error, FIFO untouched.
        to_cycle(12);
        #3;
        check("pe_req_low", 32'(bus.o_imem_req), 32'd0);
        check("pe_grants", 32'(grant_cnt), 32'd4);
        check("pe_err_before", 32'(bus.o_proto_err), 32'd0);
        to_cycle(13);
        force_rv = 1'b1;
        to_cycle(14);
        force_rv = 1'b0;
        #3;
        check("pe_err_set", 32'(bus.o_proto_err), 32'd1);
        to_cycle(17);
        #3;
        check("pe_err_sticky", 32'(bus.o_proto_err), 32'd1);
        check("pe_head_pc", bus.o_pc, 32'h0);
        check("pe_head_inst", bus.o_inst, mem_word(32'h0));
        to_cycle(18);
        push_seq(32'h0, 8);
        bus.i_ready = 1'b1;
        drain("pe_drain", -1);

        // Reset clears the sticky error (checked inside do_reset).
        do_reset(1'b0, 1);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
